// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment types, digit patterns and BCD decode function for the 7-segment driver
package seg7_pkg;

    localparam int SEG_WIDTH = 7;

    typedef logic [SEG_WIDTH-1:0] seg_t;

    // Bit order {a,b,c,d,e,f,g}, active-high for a common-cathode display.
    localparam seg_t SEG_BLANK = 7'b0000000;
    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;

    function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
        seg_t seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// rtl/seg7_digit_decode.sv - combinational decode of one BCD nibble plus decimal point to segments
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       point,
    input  logic       suppress,
    output seg_t       seg,
    output logic       dp
);

    always_comb begin
        seg = suppress ? SEG_BLANK : bcd_to_seg(nibble);
        dp  = point;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit BCD display driver with frame-aligned double buffer; SEG7_LZS_EN adds leading-zero suppression
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    upd_valid_i,
    output logic                    upd_ready_o,
    input  logic [4*NUM_DIGITS-1:0] bcd_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    blank_i,
    output logic [SEG_WIDTH-1:0]    seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   dig_o,
    output logic                    frame_o
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        div_q;
    logic [IDX_W-1:0]        idx_q;
    logic [4*NUM_DIGITS-1:0] active_bcd_q;
    logic [NUM_DIGITS-1:0]   active_dp_q;
    logic [4*NUM_DIGITS-1:0] shadow_bcd_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q;
    logic                    pending_q;
    logic                    ready_q;
    seg_t                    seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   dig_q;
    logic                    frame_q;

    logic                    digit_end;
    logic                    frame_end;
    logic                    xfer;
    logic                    pending_nxt;
    logic [3:0]              cur_nibble;
    logic                    cur_point;
    logic                    suppress;
    logic [NUM_DIGITS-1:0]   onehot;
    seg_t                    dec_seg;
    logic                    dec_dp;

    always_comb begin
        digit_end  = (div_q == DIV_LAST);
        frame_end  = digit_end && (idx_q == IDX_LAST);
        xfer       = upd_valid_i && ready_q;
        cur_nibble = active_bcd_q[{idx_q, 2'b00} +: 4];
        cur_point  = active_dp_q[idx_q];
        onehot         = '0;
        onehot[idx_q]  = 1'b1;
        // A ready transfer implies nothing is pending, so commit and capture never collide.
        pending_nxt = pending_q;
        if (frame_end && pending_q) begin
            pending_nxt = 1'b0;
        end
        if (xfer) begin
            pending_nxt = 1'b1;
        end
    end

`ifdef SEG7_LZS_EN
    logic [NUM_DIGITS-1:0] lead_zero;

    // Walk from the most-significant digit down; any nonzero value or dp ends the run.
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run          = run && (active_bcd_q[4*k +: 4] == 4'd0) && !active_dp_q[k];
            lead_zero[k] = run && (k != 0);
        end
        suppress = lead_zero[idx_q];
    end
`else
    assign suppress = 1'b0;
`endif

    seg7_digit_decode u_decode (
        .nibble   (cur_nibble),
        .point    (cur_point),
        .suppress (suppress),
        .seg      (dec_seg),
        .dp       (dec_dp)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q        <= '0;
            idx_q        <= '0;
            active_bcd_q <= '0;
            active_dp_q  <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            ready_q      <= 1'b0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b0;
            dig_q        <= '0;
            frame_q      <= 1'b0;
        end else begin
            div_q <= digit_end ? '0 : div_q + 1'b1;
            if (digit_end) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            if (frame_end && pending_q) begin
                active_bcd_q <= shadow_bcd_q;
                active_dp_q  <= shadow_dp_q;
            end
            if (xfer) begin
                shadow_bcd_q <= bcd_i;
                shadow_dp_q  <= dp_i;
            end
            pending_q <= pending_nxt;
            ready_q   <= !pending_nxt;
            frame_q   <= frame_end;
            seg_q     <= blank_i ? SEG_BLANK : dec_seg;
            dp_q      <= blank_i ? 1'b0 : dec_dp;
            dig_q     <= blank_i ? '0 : onehot;
        end
    end

    assign upd_ready_o = ready_q;
    assign seg_o       = seg_q;
    assign dp_o        = dp_q;
    assign dig_o       = dig_q;
    assign frame_o     = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver against a frame-level reference model
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int FR = ND * SD;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          upd_valid_i = 1'b0;
    logic          upd_ready_o;
    logic [15:0]   bcd_i = '0;
    logic [3:0]    dp_i = '0;
    logic          blank_i = 1'b0;
    logic [6:0]    seg_o;
    logic          dp_o;
    logic [3:0]    dig_o;
    logic          frame_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: time t counts clock edges since reset release.
    int          t;
    logic        m_pending;
    logic        m_ready;
    logic [15:0] m_abcd, m_sbcd;
    logic [3:0]  m_adp, m_sdp;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_dig;
    logic        exp_frame;

    logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
                                 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .upd_valid_i (upd_valid_i),
        .upd_ready_o (upd_ready_o),
        .bcd_i       (bcd_i),
        .dp_i        (dp_i),
        .blank_i     (blank_i),
        .seg_o       (seg_o),
        .dp_o        (dp_o),
        .dig_o       (dig_o),
        .frame_o     (frame_o)
    );

    function automatic logic [6:0] model_seg(input int k);
        logic [3:0] nib;
        nib = m_abcd[4*k +: 4];
`ifdef SEG7_LZS_EN
        if (k != 0) begin
            logic sup;
            sup = 1'b1;
            for (int j = k; j < ND; j++) begin
                if (m_abcd[4*j +: 4] != 4'd0 || m_adp[j]) sup = 1'b0;
            end
            if (sup) return 7'b0000000;
        end
`endif
        return seg_tab[nib];
    endfunction

    function automatic logic [13:0] obs_vec();
        return {seg_o, dp_o, dig_o, frame_o, upd_ready_o};
    endfunction

    function automatic logic [13:0] exp_vec();
        return {exp_seg, exp_dp, exp_dig, exp_frame, m_ready};
    endfunction

    task automatic model_reset();
        t = 0;
        m_pending = 1'b0;
        m_ready = 1'b0;
        m_abcd = '0;
        m_sbcd = '0;
        m_adp = '0;
        m_sdp = '0;
    endtask

    task automatic tick();
        int   idx;
        logic bnd;
        logic xfer;
        idx  = (t / SD) % ND;
        bnd  = (t % FR) == FR - 1;
        xfer = upd_valid_i && m_ready;
        if (blank_i) begin
            exp_seg = '0;
            exp_dp  = 1'b0;
            exp_dig = '0;
        end else begin
            exp_seg = model_seg(idx);
            exp_dp  = m_adp[idx];
            exp_dig = 4'(1 << idx);
        end
        exp_frame = bnd;
        if (bnd && m_pending) begin
            m_abcd = m_sbcd;
            m_adp = m_sdp;
            m_pending = 1'b0;
        end
        if (xfer) begin
            m_sbcd = bcd_i;
            m_sdp = dp_i;
            m_pending = 1'b1;
        end
        m_ready = !m_pending;
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int frames;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_vec() !== 14'd0) $display("FAIL reset_state got=%b exp=%b", obs_vec(), 14'd0);
        else n_pass++;
        rst_ni = 1'b1;
        model_reset();
        tick();
        n_checks++;
        if (upd_ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", upd_ready_o);
        else n_pass++;
        frames = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL idle_scan t=%0d got=%b exp=%b", t, obs_vec(), exp_vec());
            else n_pass++;
            if (frame_o) frames++;
            tick();
        end
        n_checks++;
        if (frames != 2) $display("FAIL idle_frame_count got=%0d exp=2", frames);
        else n_pass++;
    endtask

    task automatic test_update();
        while (t % FR != 6) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL update t=%0d got=%b exp=%b", t, obs_vec(), exp_vec());
            else n_pass++;
        end
        upd_valid_i = 1'b1;
        bcd_i = 16'h1234;
        dp_i = 4'b0000;
        tick();
        upd_valid_i = 1'b0;
        n_checks++;
        if (upd_ready_o !== 1'b0) $display("FAIL update_ready_low got=%b exp=0", upd_ready_o);
        else n_pass++;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL update t=%0d got=%b exp=%b", t, obs_vec(), exp_vec());
            else n_pass++;
        end
        while (t % FR != 1) tick();
        n_checks++;
        if ({dig_o, seg_o} !== {4'b0001, 7'b0110011}) $display("FAIL update_digit0 got=%b exp=%b", {dig_o, seg_o}, {4'b0001, 7'b0110011});
        else n_pass++;
    endtask

    task automatic test_collision();
        while (t % FR != 2) tick();
        upd_valid_i = 1'b1;
        bcd_i = 16'h5678;
        dp_i = 4'b0010;
        tick();
        bcd_i = 16'h9999;
        dp_i = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL collision t=%0d got=%b exp=%b", t, obs_vec(), exp_vec());
            else n_pass++;
        end
        upd_valid_i = 1'b0;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL collision t=%0d got=%b exp=%b", t, obs_vec(), exp_vec());
            else n_pass++;
        end
        while (t % FR != 1) tick();
        n_checks++;
        if (seg_o !== 7'b1111111) $display("FAIL collision_digit0 got=%b exp=%b", seg_o, 7'b1111111);
        else n_pass++;
    endtask

    task automatic test_boundary_push();
        while (t % FR != FR - 1) tick();
        upd_valid_i = 1'b1;
        bcd_i = 16'h0003;
        dp_i = 4'b0000;
        tick();
        upd_valid_i = 1'b0;
        tick();
        n_checks++;
        if (seg_o !== 7'b1111111) $display("FAIL boundary_not_yet got=%b exp=%b", seg_o, 7'b1111111);
        else n_pass++;
        for (int i = 0; i < FR; i++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL boundary t=%0d got=%b exp=%b", t, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (seg_o !== 7'b1111001) $display("FAIL boundary_commit got=%b exp=%b", seg_o, 7'b1111001);
        else n_pass++;
    endtask

    task automatic test_invalid_digits();
        while (t % FR != 4) tick();
        upd_valid_i = 1'b1;
        bcd_i = 16'hABCF;
        dp_i = 4'b0000;
        tick();
        upd_valid_i = 1'b0;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL invalid t=%0d got=%b exp=%b", t, obs_vec(), exp_vec());
            else n_pass++;
        end
        for (int i = 0; i < FR; i++) begin
            tick();
            n_checks++;
            if (seg_o !== 7'b0000000) $display("FAIL invalid_blank t=%0d got=%b exp=0000000", t, seg_o);
            else n_pass++;
        end
    endtask

    task automatic test_blank();
        int frames;
        while (t % FR != 5) tick();
        blank_i = 1'b1;
        frames = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (frame_o) frames++;
            n_checks++;
            if ({seg_o, dp_o, dig_o} !== 12'd0 || obs_vec() !== exp_vec())
                $display("FAIL blank t=%0d got=%b exp=%b", t, obs_vec(), exp_vec());
            else n_pass++;
        end
        blank_i = 1'b0;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            if (frame_o) frames++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL blank_resume t=%0d got=%b exp=%b", t, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (frames != 2) $display("FAIL blank_frame_count got=%0d exp=2", frames);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            upd_valid_i = ($urandom_range(0, 9) < 3);
            bcd_i = 16'($urandom);
            dp_i = 4'($urandom);
            blank_i = ($urandom_range(0, 9) == 0);
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL random t=%0d got=%b exp=%b", t, obs_vec(), exp_vec());
            else n_pass++;
        end
        upd_valid_i = 1'b0;
        blank_i = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int guard;
        guard = 0;
        while (!m_ready && guard < 4 * FR) begin
            tick();
            guard++;
        end
        n_checks++;
        if (upd_ready_o !== 1'b1) $display("FAIL midreset_ready_timeout got=%b exp=1", upd_ready_o);
        else n_pass++;
        upd_valid_i = 1'b1;
        bcd_i = 16'h9876;
        dp_i = 4'b1111;
        tick();
        upd_valid_i = 1'b0;
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (obs_vec() !== 14'd0) $display("FAIL midreset_async got=%b exp=%b", obs_vec(), 14'd0);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * FR + 1; i++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL midreset t=%0d got=%b exp=%b", t, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if ({dig_o, seg_o, dp_o} !== {4'b0001, 7'b1111110, 1'b0}) $display("FAIL midreset_discard got=%b exp=%b", {dig_o, seg_o, dp_o}, {4'b0001, 7'b1111110, 1'b0});
        else n_pass++;
    endtask

`ifdef SEG7_LZS_EN
    task automatic test_lzs();
        logic [15:0] words [3] = '{16'h0042, 16'h0042, 16'h0000};
        logic [3:0]  dps   [3] = '{4'b0000, 4'b0100, 4'b0000};
        logic [6:0]  dig2  [3] = '{7'b0000000, 7'b1111110, 7'b0000000};
        for (int w = 0; w < 3; w++) begin
            while (!m_ready) tick();
            upd_valid_i = 1'b1;
            bcd_i = words[w];
            dp_i = dps[w];
            tick();
            upd_valid_i = 1'b0;
            for (int i = 0; i < 2 * FR; i++) begin
                tick();
                n_checks++;
                if (obs_vec() !== exp_vec()) $display("FAIL lzs%0d t=%0d got=%b exp=%b", w, t, obs_vec(), exp_vec());
                else n_pass++;
            end
            while (t % FR != 2 * SD + 1) tick();
            n_checks++;
            if ({dig_o, seg_o} !== {4'b0100, dig2[w]}) $display("FAIL lzs%0d_digit2 got=%b exp=%b", w, {dig_o, seg_o}, {4'b0100, dig2[w]});
            else n_pass++;
        end
    endtask
`endif

    initial begin
        model_reset();
        exp_seg = '0;
        exp_dp = 1'b0;
        exp_dig = '0;
        exp_frame = 1'b0;
        test_reset();
        test_update();
        test_collision();
        test_boundary_push();
        test_invalid_digits();
        test_blank();
        test_random();
        test_reset_midflight();
`ifdef SEG7_LZS_EN
        test_lzs();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed N-digit BCD to common-cathode 7-segment display driver.
- Double-buffers a packed BCD word via a valid/ready handshake and commits it only at a frame boundary, so no digit shows a torn frame.
- Scans the digits one at a time and decodes each nibble to segments with per-digit decimal point and global blanking.
- Sits between a numeric producer (counter, measurement block) and the board-level display pins.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal 1..8.
- SCAN_DIV, 1000, clock cycles each digit stays enabled; legal >= 2.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- upd_valid_i  input  1  new display word offered.
- upd_ready_o  output  1  driver can accept a word (no commit pending).
- bcd_i  input  4*NUM_DIGITS  packed BCD; digit k = bcd_i[4k+3:4k]; digit 0 = rightmost.
- dp_i  input  NUM_DIGITS  decimal point per digit; captured with bcd_i.
- blank_i  input  1  level; forces display dark.
- seg_o  output  7  segments {a,b,c,d,e,f,g}; a = MSB; active-high (common cathode).
- dp_o  output  1  decimal point of the enabled digit; active-high.
- dig_o  output  NUM_DIGITS  one-hot digit enable; active-high.
- frame_o  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst_ni low, asynchronous) sets:
  - seg_o=0, dp_o=0, dig_o=0, frame_o=0, upd_ready_o=0.
  - Divider=0, digit index=0.
  - Active and shadow buffers = all-zero BCD, dp=0; pending=0.
- First rising edge after release: upd_ready_o=1; scanning starts.
- Reset mid-frame or mid-handshake discards all state, including any pending word.
- Divider counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the index advances, with NUM_DIGITS-1 wrapping to 0.
- Frame boundary = divider==SCAN_DIV-1 and index==NUM_DIGITS-1. On that edge:
  - frame_o=1 for exactly one cycle.
  - If pending=1: active<=shadow and pending<=0, so upd_ready_o returns to 1 on the next cycle.
- Handshake:
  - A transfer occurs when upd_valid_i & upd_ready_o on a clock edge.
  - shadow<=bcd_i/dp_i, pending<=1, upd_ready_o<=0 on that edge.
  - upd_valid_i with ready=0 is ignored; the producer holds the word.
- Same-cycle transfer and frame boundary: the word enters shadow and commits at the next boundary. Commit uses the registered pending only.
- Outputs are registered; one cycle lag from the index.
  - dig_o = one-hot(index).
  - seg_o = decode(active[index]).
  - dp_o = active_dp[index].
- A committed word appears on digit 0 one cycle after the commit edge.
- Decode table:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - 10..15 = 0000000 (blank, never X/Z)
- blank_i=1: the next registered seg_o, dp_o and dig_o are all 0. The divider, index, frame_o and handshake keep running; deassertion resumes at the current index.
- NUM_DIGITS=1: index is constant 0; a frame boundary occurs every SCAN_DIV cycles.

Optional Feature:
- Macro SEG7_LZS_EN: leading-zero suppression.
- Defined:
  - Digits above the most-significant nonzero digit, with value 0 and dp=0, decode to 0000000.
  - Digit 0 is never suppressed.
  - A suppressed digit's dig_o bit still asserts.
  - A digit with dp=1 stops suppression at and below it.
- Undefined: all digits decoded literally; no suppression logic synthesised.

Decomposition:
- Package seg7_pkg:
  - SEG_WIDTH=7.
  - seg_t typedef (logic [6:0]).
  - SEG_BLANK constant.
  - Digit-pattern constants SEG_0..SEG_9.
  - Function bcd_to_seg(logic [3:0]) returning seg_t.
- Sub-module seg7_digit_decode: combinational nibble+dp+suppress to seg/dp, one instance on the muxed digit.
- Top holds the divider, index, buffers, handshake and output registers.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4):
- Reset release, no update -> dig_o cycles 0001,0010,0100,1000 every 4 clocks; seg_o=1111110; frame_o pulses every 16 clocks; upd_ready_o=1 one clock after release.
- Push bcd_i=16'h1234 mid-frame -> upd_ready_o=0 until the boundary. The next frame shows dig 0001/seg 0110011 (4), 0010/1111001 (3), 0100/1101101 (2), 1000/0110000 (1).
- Handshake collisions:
  - Push 16'h5678, then push 16'h9999 while ready=0 -> second word ignored; display 5678.
  - Push on the boundary cycle -> commits one frame later.
- bcd_i=16'hABCF -> seg_o=0000000 on all digits; no X on any output.
- blank_i=1 for 6 clocks mid-scan -> seg_o/dp_o/dig_o=0 during that window; frame_o period unchanged; scan resumes at the correct digit.
- SEG7_LZS_EN defined, 16'h0042 with dp_i=4'b0000 -> digits 3,2 blank, digits 1,0 show 4,2. With dp_i=4'b0100 -> digit 2 shows 0 with dp. 16'h0000 -> only digit 0 shows 0.
